// File: rtl/io_controller_if.sv
// CPU data-bus view of the I/O controller: byte address, read/write strobes and data.
interface io_controller_if;
  logic [7:0]  addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output ren, output wen, output wdata, input rdata);
  modport slave  (input addr, input ren, input wen, input wdata, output rdata);
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: debounced button-latched operands from the switches,
// plus a CPU-written 32-bit word scanned onto the 8-digit seven-segment display.
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic              CLK100MHZ,
  input  logic              BTNC,
  input  logic              BTNL,
  input  logic              BTNR,
  input  logic [15:0]       SW,
  io_controller_if.slave    bus,
  output logic [7:0]        AN,
  output logic [6:0]        A2G
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCW = $clog2(SCAN_CYCLES + 1);

  // Index 1 is the left button, index 0 the right button.
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, press;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;

  logic        lval_q, lval_d, rval_q, rval_d, ovf_q, ovf_d;
  logic [7:0]  left_q, left_d, right_q, right_d;
  logic [31:0] disp_q, disp_d;

  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]     digit_q, digit_d;
  logic [7:0]     an_q, an_d;
  logic [6:0]     a2g_q, a2g_d;

  logic sel_status, sel_left, sel_right, sel_disp;
  wire  unused_addr_bits = ^bus.addr[1:0];

  function automatic logic [6:0] seg(input logic [3:0] nib);
    case (nib)
      4'h0: seg = 7'b0000001;  4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;  4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;  4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;  4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;  4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;  default: seg = 7'b0111000;
    endcase
  endfunction

  assign sel_status = (bus.addr[7:2] == 6'h20);
  assign sel_left   = (bus.addr[7:2] == 6'h21);
  assign sel_right  = (bus.addr[7:2] == 6'h22);
  assign sel_disp   = (bus.addr[7:2] == 6'h23);

  // A level change must persist through a full counter run before it becomes stable.
  always_comb begin
    sync1_d  = {BTNL, BTNR};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1))
          stable_d[i] = sync2_q[i];
        else
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    press = stable_d & ~stable_q;
  end

  // Press events are applied after the clears so a same-cycle press wins.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    lval_d  = lval_q;
    rval_d  = rval_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    if (bus.wen && sel_status) begin
      if (bus.wdata[0]) rval_d = 1'b0;
      if (bus.wdata[1]) lval_d = 1'b0;
      if (bus.wdata[2]) ovf_d  = 1'b0;
    end
    if (bus.ren && sel_left)  lval_d = 1'b0;
    if (bus.ren && sel_right) rval_d = 1'b0;
    if (bus.wen && sel_disp)  disp_d = bus.wdata;
    if (press[1]) begin
      left_d = SW[15:8];
      lval_d = 1'b1;
      if (lval_q) ovf_d = 1'b1;
    end
    if (press[0]) begin
      right_d = SW[7:0];
      rval_d  = 1'b1;
      if (rval_q) ovf_d = 1'b1;
    end
  end

  always_comb begin
    case (bus.addr[7:2])
      6'h20:   bus.rdata = {29'b0, ovf_q, lval_q, rval_q};
      6'h21:   bus.rdata = {24'b0, left_q};
      6'h22:   bus.rdata = {24'b0, right_q};
      6'h23:   bus.rdata = disp_q;
      default: bus.rdata = '0;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 1'b1;
    end
    an_d  = ~(8'b1 << digit_q);
    a2g_d = seg(disp_q[{digit_q, 2'b00} +: 4]);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      db_cnt_q   <= '0;
      lval_q     <= 1'b0;
      rval_q     <= 1'b0;
      ovf_q      <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      disp_q     <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      an_q       <= 8'hFF;
      a2g_q      <= 7'h7F;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      lval_q     <= lval_d;
      rval_q     <= rval_d;
      ovf_q      <= ovf_d;
      left_q     <= left_d;
      right_q    <= right_d;
      disp_q     <= disp_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      a2g_q      <= a2g_d;
    end
  end

  assign AN  = an_q;
  assign A2G = a2g_q;

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped I/O controller between the single-cycle CPU data bus and the Nexys board peripherals.
- Debounces BTNL/BTNR. On each press it latches an operand byte from SW into a register with a valid flag, for the CPU to poll.
- Holds a 32-bit display word written by the CPU and time-multiplexes it onto the 8-digit seven-segment display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- SCAN_CYCLES, 100000, cycles each display digit stays lit (1 ms).

Ports:
- CLK100MHZ  input  1  system clock; all state updates on rising edge.
- BTNC  input  1  reset, synchronous, active-high.
- BTNL  input  1  raw left button; a press latches SW[15:8] as left operand.
- BTNR  input  1  raw right button; a press latches SW[7:0] as right operand.
- SW  input  16  raw slide switches.
- addr  input  8  CPU byte address; bits [1:0] ignored.
- ren  input  1  CPU read strobe.
- wen  input  1  CPU write strobe.
- wdata  input  32  CPU write data.
- rdata  output  32  CPU read data; combinational from addr.
- AN  output  8  digit enables, active-low, one-hot.
- A2G  output  7  segments {a,b,c,d,e,f,g}, active-low.

Behaviour:
- Reset, while BTNC=1 at a clock edge:
  - lval, rval, ovf = 0; left, right, disp = 0.
  - Debounce counters = 0; stable levels = 0.
  - scan_cnt = 0; digit = 0.
  - AN = 8'hFF; A2G = 7'h7F.
  - Reset mid-debounce or mid-scan aborts it with no press event.
- Button path, per button:
  - Two-flop synchronizer.
  - If the synchronized level equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized value and the counter clears.
  - A press event is a single-cycle pulse on a stable 0->1 transition. Release generates nothing.
  - Latency: lval/rval is visible at most DEBOUNCE_CYCLES+3 cycles after the raw rise held steady.
- Press event:
  - Left: left <= SW[15:8] sampled in the event cycle; lval <= 1; if lval was already 1, ovf <= 1.
  - Right: right <= SW[7:0]; rval <= 1; overrun sets ovf in the same way.
  - Both presses in the same cycle: both latch independently.
- Register map (addr[7:0]); unmapped addresses read 0 and ignore writes:
  - 8'h80 STATUS. Read {29'b0, ovf, lval, rval}. Write: wdata[0]=1 clears rval, [1]=1 clears lval, [2]=1 clears ovf.
  - 8'h84 LEFT. Read {24'b0, left}. ren clears lval at the edge.
  - 8'h88 RIGHT. Read {24'b0, right}. ren clears rval at the edge.
  - 8'h8C DISP. Read disp. Write disp <= wdata.
- Simultaneous clear (ren or STATUS write) and press event on the same flag: the press wins. The flag stays 1 and the data is the new byte.
- Scan:
  - scan_cnt counts 0..SCAN_CYCLES-1. At the terminal count it wraps to 0 and digit <= digit+1 (mod 8, 7 wraps to 0).
  - AN and A2G are registered every non-reset cycle from the current digit and disp:
    - AN = ~(8'b1 << digit).
    - A2G = seg(disp[4*digit+3 : 4*digit]).
  - Outputs therefore lag digit by 1 cycle. The first non-reset edge gives AN=8'hFE.
  - A DISP write takes effect on the next registered output update; the scan is not restarted.
- seg() table, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, SCAN_CYCLES=3.
- Reset: BTNC=1 for 2 cycles, all other inputs 0 -> AN=8'hFF, A2G=7'h7F, rdata@80=0, rdata@8C=0. One cycle after release -> AN=8'hFE, A2G=7'b0000001.
- Operand latch:
  - SW=16'h0408; BTNL high 12 cycles -> within 7 cycles of rise rdata@80=32'h2 and rdata@84=32'h04.
  - Then BTNR high 12 cycles -> rdata@80=32'h3, rdata@88=32'h08.
  - ren at 84 -> next cycle rdata@80=32'h1.
- Glitch reject: BTNL high 2 cycles then low -> STATUS stays 0, left unchanged, for 20 cycles.
- Overrun:
  - After a left latch of 8'h04, set SW[15:8]=8'h11 and press BTNL again -> rdata@84=32'h11, rdata@80=32'h6.
  - Write 80 with 32'h4 -> rdata@80=32'h2.
- Race: ren at 84 in the same cycle as a left press event (SW[15:8]=8'h22) -> rdata@80[1]=1, rdata@84=32'h22.
- Display scan:
  - Write 8C with 32'h89ABCDEF.
  - Expected sequence, each held 3 cycles: AN=FE/A2G=0111000, FD/0110000, FB/1000010, F7/0110001, EF/1100000, DF/0001000, BF/0000100, 7F/0000000, then FE again.
  - Assert BTNC mid-scan -> AN=8'hFF; after release the scan restarts at digit 0.
